// File: rtl/reaction_capture.sv
// Reaction-round capture: button conditioning, random pre-stimulus delay and BCD ms timing.
// Define BEST_TIME_EN to track the best (lowest) valid result in best_bcd.
module reaction_capture #(
  parameter int CLK_HZ       = 100000000,
  parameter int DEBOUNCE_MS  = 10,
  parameter int DELAY_MIN_MS = 1000,
  parameter int DELAY_MASK   = 2047
) (
  input  logic        clk,
  input  logic        ck_rst,
  input  logic        btn_raw,
  output logic        stim_led,
  output logic [15:0] result_bcd,
  output logic        result_valid,
  output logic        foul,
  output logic        timeout,
  output logic [2:0]  state_o,
  output logic [15:0] best_bcd
);

  localparam int TICK_DIV  = CLK_HZ / 1000;
  localparam int DB_CYCLES = DEBOUNCE_MS * TICK_DIV;
  localparam int PW        = $clog2(TICK_DIV + 1);
  localparam int DBW       = $clog2(DB_CYCLES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FOUL  = 3'd4;

  logic [1:0]     sync_q;
  logic           db_level;
  logic           db_prev;
  logic [DBW-1:0] db_cnt;
  logic [PW-1:0]  pre_cnt;
  logic [15:0]    lfsr;
  logic [15:0]    delay_cnt;
  logic [15:0]    bcd_cnt;
  logic [2:0]     state;
  logic           press;
  logic           tick;
  logic           arm_now;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign press   = db_level & ~db_prev;
  assign tick    = (pre_cnt == PW'(TICK_DIV - 1));
  assign arm_now = (state == S_WAIT) && !press && tick && (delay_cnt == 16'd1);
  assign state_o = state;

  // Debounced level only moves after the synchronised input has disagreed for a full window
  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      sync_q   <= 2'b00;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      db_prev <= db_level;
      if (sync_q[1] != db_level) begin
        if (db_cnt == DBW'(DB_CYCLES - 1)) begin
          db_level <= sync_q[1];
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DBW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Prescaler restarts when the lamp lights so the first counted ms is a whole one
  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      pre_cnt <= '0;
      lfsr    <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (arm_now || tick) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      state        <= S_IDLE;
      stim_led     <= 1'b0;
      result_bcd   <= 16'h0000;
      result_valid <= 1'b0;
      foul         <= 1'b0;
      timeout      <= 1'b0;
      delay_cnt    <= 16'd0;
      bcd_cnt      <= 16'h0000;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FOUL: begin
          if (press) begin
            delay_cnt    <= 16'(DELAY_MIN_MS) + (lfsr & 16'(DELAY_MASK));
            result_valid <= 1'b0;
            foul         <= 1'b0;
            timeout      <= 1'b0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (press) begin
            foul  <= 1'b1;
            state <= S_FOUL;
          end else if (tick) begin
            if (delay_cnt == 16'd1) begin
              stim_led <= 1'b1;
              bcd_cnt  <= 16'h0000;
              state    <= S_ARMED;
            end else begin
              delay_cnt <= delay_cnt - 16'd1;
            end
          end
        end
        S_ARMED: begin
          // A press in the same cycle as a tick keeps the value before that tick
          if (press) begin
            result_bcd   <= bcd_cnt;
            result_valid <= 1'b1;
            stim_led     <= 1'b0;
            state        <= S_DONE;
          end else if (tick) begin
            if (bcd_cnt == 16'h9999) begin
              timeout      <= 1'b1;
              result_valid <= 1'b0;
              result_bcd   <= 16'h9999;
              stim_led     <= 1'b0;
              state        <= S_DONE;
            end else begin
              bcd_cnt <= bcd_inc(bcd_cnt);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BEST_TIME_EN
  logic [15:0] best_q;

  // Packed BCD compares correctly as an unsigned number, most significant digit first
  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      best_q <= 16'h9999;
    end else if ((state == S_ARMED) && press && (bcd_cnt < best_q)) begin
      best_q <= bcd_cnt;
    end
  end

  assign best_bcd = best_q;
`else
  assign best_bcd = 16'h9999;
`endif

endmodule

// File: doc/reaction_capture.md
Name: reaction_capture

Overview:
- Input-side counterpart of the reaction timer's display path: conditions the raw player button, runs one reaction round, and produces the measured reaction time as 4-digit BCD.
- A press starts a round. After a pseudo-random delay the stimulus LED lights. The elapsed milliseconds until the next press are counted.
- The BCD result feeds the digit/seven-segment path. Status flags drive LEDs.

Parameters:
- CLK_HZ, 100000000, input clock frequency; CLK_HZ/1000 must be an integer ≥1.
- DEBOUNCE_MS, 10, button must be stable this many ms before a level change is accepted.
- DELAY_MIN_MS, 1000, minimum pre-stimulus delay in ms.
- DELAY_MASK, 2047, mask applied to the LFSR for the random extra delay in ms (2^n−1).

Ports:
- clk  in  1  system clock
- ck_rst  in  1  asynchronous reset, active-low
- btn_raw  in  1  raw asynchronous push-button, active-high
- stim_led  out  1  stimulus lamp; high while the reaction is being timed
- result_bcd  out  16  {thousands, hundreds, tens, ones} ms, BCD
- result_valid  out  1  result_bcd holds a completed measurement
- foul  out  1  press occurred before the stimulus
- timeout  out  1  no press before 9999 ms
- state_o  out  3  current FSM state encoding, for debug
- best_bcd  out  16  best result (see Optional Feature)

Behaviour:
- Reset (ck_rst low, async) forces:
  - all outputs 0, except best_bcd = 16'h9999
  - FSM to IDLE
  - LFSR to 16'hACE1
  - all counters to 0
- Synchroniser: btn_raw passes through a 2-flop synchroniser.
- Debouncer: the debounced level changes only after the synchronised input differs from it for DEBOUNCE_MS×CLK_HZ/1000 consecutive cycles. Any bounce restarts the count.
- press: 1-cycle pulse on the debounced rising edge. Release is ignored.
- ms tick:
  - Prescaler pulses every CLK_HZ/1000 cycles.
  - Prescaler is cleared on entry to ARMED, so the first tick comes exactly CLK_HZ/1000 cycles after stim_led rises.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle, never zero.
- FSM states: IDLE=0, WAIT=1, ARMED=2, DONE=3, FOUL=4.
- IDLE, DONE, FOUL on press:
  - load delay = DELAY_MIN_MS + (lfsr & DELAY_MASK)
  - clear result_valid, foul, timeout; result_bcd keeps its old value
  - go to WAIT
- WAIT:
  - Each ms tick decrements delay.
  - Tick with delay==1 → ARMED: stim_led=1, BCD counter=0.
  - press → FOUL: foul=1, stim_led stays 0.
  - press and the final tick in the same cycle → FOUL (press wins).
- ARMED:
  - Each tick increments the 4-digit BCD counter with per-digit carry (9→0).
  - press → DONE: result_bcd=counter value, result_valid=1, stim_led=0.
  - press and tick in the same cycle: latch the pre-increment value.
  - Tick while counter==9999 → DONE: timeout=1, result_valid=0, result_bcd=16'h9999, stim_led=0.
- Latency:
  - result_bcd, result_valid and stim_led update on the clock edge after the press pulse cycle.
  - Measured time includes synchroniser + debounce latency. This is not compensated.
- Outputs are registered. No combinational path from btn_raw to any output.

Optional Feature:
- Macro BEST_TIME_EN.
- Defined:
  - best_bcd holds the minimum valid result since reset.
  - Updated in the same cycle result_valid rises, if the new result < best_bcd (BCD compare, most significant digit first).
  - Foul and timeout never update it.
- Undefined: best_bcd is constant 16'h9999 and no comparator is built.

Test Plan:
- Bench settings: CLK_HZ=10000 (10 cycles/ms), DEBOUNCE_MS=1, DELAY_MIN_MS=5, DELAY_MASK=3.
- Normal round:
  - Clean press, wait for stim_led rise, press again 437 ms after it, hold.
  - Expect result_bcd=16'h0437 + debounce/sync ms (bench computes exact), result_valid=1, stim_led=0, state_o=3.
- Foul: press, then press again 2 ms later (< DELAY_MIN_MS) → foul=1, stim_led never high, state_o=4, result_valid=0.
- Timeout: start round, never press after stim_led → after 9999 ticks: timeout=1, result_bcd=16'h9999, result_valid=0, stim_led=0.
- Bounce rejection:
  - Toggle btn_raw every 3 cycles for 40 cycles, then hold high → exactly one press; FSM IDLE→WAIT once.
  - A 5-cycle glitch in WAIT → no foul.
- Reset mid-ARMED: drop ck_rst with stim_led=1 → outputs 0 immediately (async), state_o=0, best_bcd=16'h9999; next press starts a fresh round.
- BEST_TIME_EN: rounds giving 0312, 0280, 0455, then a foul → best_bcd=16'h0280. Without the macro, best_bcd=16'h9999 throughout.
